// File: rtl/sparse_to_dense_if.sv
// AXI4 bundle (32-bit data, single-bit IDs) between sparse_to_dense and its memory.
// master: the scatter engine; slave: the memory/interconnect side.
interface sparse_to_dense_if;
   // Read address
   logic        ARREADY;
   logic        ARVALID;
   logic [31:0] ARADDR;
   logic [7:0]  ARLEN;
   logic [2:0]  ARSIZE;
   logic [1:0]  ARBURST;
   logic        ARID;
   logic        ARLOCK;
   logic [3:0]  ARCACHE;
   logic [2:0]  ARPROT;
   logic [3:0]  ARQOS;
   // Read data
   logic        RREADY;
   logic        RVALID;
   logic [31:0] RDATA;
   logic        RID;
   logic        RLAST;
   logic [1:0]  RRESP;
   // Write address
   logic        AWREADY;
   logic        AWVALID;
   logic [31:0] AWADDR;
   logic [7:0]  AWLEN;
   logic [2:0]  AWSIZE;
   logic [1:0]  AWBURST;
   logic        AWID;
   logic        AWLOCK;
   logic [3:0]  AWCACHE;
   logic [2:0]  AWPROT;
   logic [3:0]  AWQOS;
   // Write data
   logic        WREADY;
   logic        WVALID;
   logic [31:0] WDATA;
   logic [3:0]  WSTRB;
   logic        WLAST;
   // Write response
   logic        BREADY;
   logic        BVALID;
   logic        BID;
   logic [1:0]  BRESP;

   modport master (
      input  ARREADY,
      output ARVALID, ARADDR, ARLEN, ARSIZE, ARBURST, ARID, ARLOCK, ARCACHE, ARPROT, ARQOS,
      output RREADY,
      input  RVALID, RDATA, RID, RLAST, RRESP,
      input  AWREADY,
      output AWVALID, AWADDR, AWLEN, AWSIZE, AWBURST, AWID, AWLOCK, AWCACHE, AWPROT, AWQOS,
      input  WREADY,
      output WVALID, WDATA, WSTRB, WLAST,
      output BREADY,
      input  BVALID, BID, BRESP
   );

   modport slave (
      output ARREADY,
      input  ARVALID, ARADDR, ARLEN, ARSIZE, ARBURST, ARID, ARLOCK, ARCACHE, ARPROT, ARQOS,
      input  RREADY,
      output RVALID, RDATA, RID, RLAST, RRESP,
      output AWREADY,
      input  AWVALID, AWADDR, AWLEN, AWSIZE, AWBURST, AWID, AWLOCK, AWCACHE, AWPROT, AWQOS,
      output WREADY,
      input  WVALID, WDATA, WSTRB, WLAST,
      input  BREADY,
      output BVALID, BID, BRESP
   );
endinterface

// File: rtl/sparse_to_dense.sv
// sparse_to_dense: scatter engine. Reads a list of 32-bit vertex indices and writes
// io_writeValue to denseBase + 4*idx for each one, over a single AXI4 master.
// Optional build macro SPARSE_TO_DENSE_ERRCNT_EN adds io_errorCount (non-OKAY R/B beats).
module sparse_to_dense #(
   parameter int unsigned QUEUE_DEPTH = 32,
   parameter int unsigned BURST_MAX   = 8,
   parameter int unsigned MAX_OUTB    = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [31:0]        io_sparseBasePtr,
   input  logic [31:0]        io_denseBasePtr,
   input  logic [31:0]        io_sparseCount,
   input  logic [31:0]        io_writeValue,
   input  logic               io_start,
   output logic               io_finished,
   output logic [31:0]        io_writeCount,
`ifdef SPARSE_TO_DENSE_ERRCNT_EN
   output logic [31:0]        io_errorCount,
`endif
   sparse_to_dense_if.master  aximm32
);

   localparam int unsigned PTR_W  = $clog2(QUEUE_DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned OUTB_W = $clog2(MAX_OUTB + 1);

   typedef enum logic [1:0] {StIdle, StRun, StFinished} state_e;

   state_e              state_q;
   logic [31:0]         ar_addr_q, dense_base_q, count_q, value_q, reads_left_q;
   logic                arvalid_q;
   logic [7:0]          arlen_q;
   logic [CNT_W-1:0]    ar_beats_q, inflight_q, fifo_cnt_q;
   logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
   logic [31:0]         fifo_mem [QUEUE_DEPTH];
   logic                awvalid_q, wvalid_q, rready_q, bready_q;
   logic [31:0]         awaddr_q, writes_issued_q, write_count_q;
   logic [OUTB_W-1:0]   outb_q;

   logic                ar_hs, r_hs, aw_hs, w_hs, b_hs;
   logic                hold_free, pop, ar_launch, all_done;
   logic [CNT_W-1:0]    free_slots, next_beats;
   logic [31:0]         head_idx;

   assign ar_hs = arvalid_q & aximm32.ARREADY;
   assign r_hs  = aximm32.RVALID & rready_q;
   assign aw_hs = awvalid_q & aximm32.AWREADY;
   assign w_hs  = wvalid_q & aximm32.WREADY;
   assign b_hs  = aximm32.BVALID & bready_q;

   // Holding register is free once both AW and W have handshaken (possibly this cycle).
   assign hold_free = ~(awvalid_q & ~aw_hs) & ~(wvalid_q & ~w_hs);
   assign pop = (state_q == StRun) & hold_free & (fifo_cnt_q != '0)
              & (outb_q < OUTB_W'(MAX_OUTB));

   // In-flight read beats hold reserved slots so R data can always be accepted.
   assign free_slots = CNT_W'(QUEUE_DEPTH) - fifo_cnt_q - inflight_q;
   assign next_beats = (reads_left_q < 32'(BURST_MAX)) ? CNT_W'(1) : CNT_W'(BURST_MAX);
   assign ar_launch  = (state_q == StRun) & ~arvalid_q & (reads_left_q != '0)
                     & (free_slots >= next_beats);

   assign all_done = (writes_issued_q == count_q) & (write_count_q == count_q) & (outb_q == '0);
   assign head_idx = fifo_mem[rd_ptr_q];

   // Index FIFO storage; no reset needed, occupancy is tracked separately.
   always_ff @(posedge clk) begin
      if (r_hs) fifo_mem[wr_ptr_q] <= aximm32.RDATA;
   end

   // Control FSM plus read, write and response bookkeeping.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= StIdle;
         ar_addr_q       <= '0;
         dense_base_q    <= '0;
         count_q         <= '0;
         value_q         <= '0;
         reads_left_q    <= '0;
         arvalid_q       <= 1'b0;
         arlen_q         <= '0;
         ar_beats_q      <= '0;
         inflight_q      <= '0;
         fifo_cnt_q      <= '0;
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         awvalid_q       <= 1'b0;
         wvalid_q        <= 1'b0;
         awaddr_q        <= '0;
         rready_q        <= 1'b0;
         bready_q        <= 1'b0;
         writes_issued_q <= '0;
         write_count_q   <= '0;
         outb_q          <= '0;
      end else begin
         // Read address channel: ARVALID/ARADDR/ARLEN stay stable until accepted.
         if (ar_launch) begin
            arvalid_q  <= 1'b1;
            arlen_q    <= 8'(next_beats - CNT_W'(1));
            ar_beats_q <= next_beats;
         end else if (ar_hs) begin
            arvalid_q    <= 1'b0;
            ar_addr_q    <= ar_addr_q + {(32 - CNT_W - 2)'(0), ar_beats_q, 2'b00};
            reads_left_q <= reads_left_q - 32'(ar_beats_q);
         end
         inflight_q <= inflight_q + (ar_launch ? next_beats : CNT_W'(0)) - CNT_W'(r_hs);

         // FIFO occupancy and pointers.
         fifo_cnt_q <= fifo_cnt_q + CNT_W'(r_hs) - CNT_W'(pop);
         if (r_hs) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);

         // Write side: AW and W raised together, each dropped on its own handshake.
         if (pop) begin
            awvalid_q       <= 1'b1;
            wvalid_q        <= 1'b1;
            awaddr_q        <= dense_base_q + (head_idx << 2);
            writes_issued_q <= writes_issued_q + 32'd1;
         end else begin
            if (aw_hs) awvalid_q <= 1'b0;
            if (w_hs)  wvalid_q  <= 1'b0;
         end
         outb_q        <= outb_q + OUTB_W'(pop) - OUTB_W'(b_hs);
         write_count_q <= write_count_q + 32'(b_hs);

         // State transitions last so run-start clears take priority.
         case (state_q)
            StIdle: begin
               if (io_start) begin
                  state_q         <= StRun;
                  ar_addr_q       <= io_sparseBasePtr;
                  dense_base_q    <= io_denseBasePtr;
                  count_q         <= io_sparseCount;
                  value_q         <= io_writeValue;
                  reads_left_q    <= io_sparseCount;
                  writes_issued_q <= '0;
                  write_count_q   <= '0;
                  outb_q          <= '0;
                  rready_q        <= 1'b1;
                  bready_q        <= 1'b1;
               end
            end
            StRun: begin
               if (all_done) begin
                  state_q  <= StFinished;
                  rready_q <= 1'b0;
               end
            end
            StFinished: begin
               if (!io_start) begin
                  state_q  <= StIdle;
                  bready_q <= 1'b0;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

`ifdef SPARSE_TO_DENSE_ERRCNT_EN
   logic [31:0] err_cnt_q;
   logic        r_err, b_err;

   assign r_err = r_hs & (aximm32.RRESP != 2'b00);
   assign b_err = b_hs & (aximm32.BRESP != 2'b00);

   // Error beats are only counted; data and responses flow as usual.
   always_ff @(posedge clk) begin
      if (reset) begin
         err_cnt_q <= '0;
      end else if (state_q == StIdle && io_start) begin
         err_cnt_q <= '0;
      end else begin
         err_cnt_q <= err_cnt_q + 32'(r_err) + 32'(b_err);
      end
   end

   assign io_errorCount = err_cnt_q;

   logic unused_inputs;
   assign unused_inputs = ^{aximm32.RID, aximm32.RLAST, aximm32.BID};
`else
   logic unused_inputs;
   assign unused_inputs = ^{aximm32.RID, aximm32.RLAST, aximm32.RRESP, aximm32.BID,
                            aximm32.BRESP};
`endif

   assign io_finished   = (state_q == StFinished);
   assign io_writeCount = write_count_q;

   assign aximm32.ARVALID = arvalid_q;
   assign aximm32.ARADDR  = ar_addr_q;
   assign aximm32.ARLEN   = arlen_q;
   assign aximm32.ARSIZE  = 3'd2;
   assign aximm32.ARBURST = 2'd1;
   assign aximm32.ARID    = 1'b0;
   assign aximm32.ARLOCK  = 1'b0;
   assign aximm32.ARCACHE = 4'd2;
   assign aximm32.ARPROT  = 3'd0;
   assign aximm32.ARQOS   = 4'd0;
   assign aximm32.RREADY  = rready_q;

   assign aximm32.AWVALID = awvalid_q;
   assign aximm32.AWADDR  = awaddr_q;
   assign aximm32.AWLEN   = 8'd0;
   assign aximm32.AWSIZE  = 3'd2;
   assign aximm32.AWBURST = 2'd1;
   assign aximm32.AWID    = 1'b0;
   assign aximm32.AWLOCK  = 1'b0;
   assign aximm32.AWCACHE = 4'd2;
   assign aximm32.AWPROT  = 3'd0;
   assign aximm32.AWQOS   = 4'd0;

   assign aximm32.WVALID  = wvalid_q;
   assign aximm32.WDATA   = value_q;
   assign aximm32.WSTRB   = 4'hF;
   assign aximm32.WLAST   = 1'b1;
   assign aximm32.BREADY  = bready_q;

endmodule
